// File: rtl/pin_verifier.sv
// Keypad PIN verifier: collects 4 BCD digits, checks them against a stored PIN,
// locks out after repeated failures. Optional inter-key timeout: `PIN_TIMEOUT_EN.
module pin_verifier #(
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          LOCK_CYCLES    = 250_000_000,
    parameter int          TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        pin_set,
    input  logic [15:0] pin_new,
    output logic        pin_check,
    output logic        pin_fail,
    output logic        locked,
    output logic [2:0]  digit_count
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OK,
        S_FAIL,
        S_LOCKED
    } state_t;

    state_t          state_q;
    logic [15:0]     pin_q;
    logic [15:0]     buf_q;
    logic [2:0]      cnt_q;
    logic            ovf_q;
    logic [2:0]      fail_q;
    logic [LW-1:0]   lock_q;
    logic            pin_check_q;
    logic            pin_fail_q;
    logic            locked_q;

    logic            is_digit;
    logic            is_clear;
    logic            is_enter;
    logic [3:0]      nib_ok;
    logic            pin_new_ok;
    logic            pin_match;
    logic [2:0]      fail_inc;

`ifdef PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tmo_q;
`else
    logic            unused_tmo_param;
    assign unused_tmo_param = (TIMEOUT_CYCLES != 0);
`endif

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == 4'hA);
    assign is_enter = key_valid && (key_code == 4'hB);

    // A new PIN is only accepted if every nibble is a legal BCD digit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign nib_ok[gi] = (pin_new[4*gi+3 -: 4] <= 4'd9);
    end
    assign pin_new_ok = &nib_ok;

    assign pin_match = (cnt_q == 3'd4) && !ovf_q && (buf_q == pin_q);
    assign fail_inc  = fail_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pin_q       <= DEFAULT_PIN;
            buf_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            fail_q      <= '0;
            lock_q      <= '0;
            pin_check_q <= 1'b0;
            pin_fail_q  <= 1'b0;
            locked_q    <= 1'b0;
`ifdef PIN_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            pin_check_q <= 1'b0;
            pin_fail_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (is_digit) begin
                        buf_q   <= {buf_q[11:0], key_code};
                        cnt_q   <= 3'd1;
                        state_q <= S_ENTRY;
`ifdef PIN_TIMEOUT_EN
                        tmo_q   <= TW'(TIMEOUT_CYCLES);
`endif
                    end else if (pin_set && !key_valid && pin_new_ok) begin
                        pin_q <= pin_new;
                    end
                end
                S_ENTRY: begin
                    if (is_digit) begin
                        if (cnt_q < 3'd4) begin
                            buf_q <= {buf_q[11:0], key_code};
                            cnt_q <= cnt_q + 3'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
`ifdef PIN_TIMEOUT_EN
                        tmo_q <= TW'(TIMEOUT_CYCLES);
`endif
                    end else if (is_clear) begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (is_enter) begin
                        state_q <= S_CHECK;
`ifdef PIN_TIMEOUT_EN
                    end else if (tmo_q == TW'(1)) begin
                        // Abandoned entry: silently discarded, not counted as a failure.
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
`endif
                    end
                end
                S_CHECK: begin
                    if (pin_match) begin
                        pin_check_q <= 1'b1;
                        state_q     <= S_OK;
                    end else begin
                        // locked rises together with the final failure pulse.
                        pin_fail_q <= 1'b1;
                        fail_q     <= fail_inc;
                        locked_q   <= (fail_inc == 3'(MAX_TRIES));
                        state_q    <= S_FAIL;
                    end
                end
                S_OK: begin
                    fail_q  <= '0;
                    buf_q   <= '0;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    buf_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    if (locked_q) begin
                        lock_q  <= LW'(LOCK_CYCLES);
                        state_q <= S_LOCKED;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    if (lock_q == LW'(1)) begin
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        lock_q <= lock_q - LW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pin_check   = pin_check_q;
    assign pin_fail    = pin_fail_q;
    assign locked      = locked_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_pin_verifier.sv
// Directed, table-driven bench for pin_verifier with LOCK_CYCLES=20, TIMEOUT_CYCLES=10.
module tb_pin_verifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        pin_set = 1'b0;
    logic [15:0] pin_new = 16'd0;
    logic        pin_check;
    logic        pin_fail;
    logic        locked;
    logic [2:0]  digit_count;

    int checks = 0;
    int errors = 0;

    pin_verifier #(
        .DEFAULT_PIN   (16'h1234),
        .MAX_TRIES     (3),
        .LOCK_CYCLES   (20),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .pin_set    (pin_set),
        .pin_new    (pin_new),
        .pin_check  (pin_check),
        .pin_fail   (pin_fail),
        .locked     (locked),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // keys: first key in bits [31:28]; exp_cnt is digit_count just before the last key.
    typedef struct packed {
        logic        do_set;
        logic [15:0] set_val;
        logic [3:0]  nkeys;
        logic [31:0] keys;
        logic [2:0]  exp_cnt;
        logic        exp_check;
        logic        exp_fail;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic load_pin(input logic [15:0] v);
        pin_set = 1'b1;
        pin_new = v;
        @(posedge clk);
        #1;
        pin_set = 1'b0;
    endtask

    task automatic attempt(input string name, input logic [3:0] n, input logic [31:0] keys,
                           input logic [2:0] exp_cnt, input logic exp_c, input logic exp_f,
                           input logic exp_l);
        logic c0, f0, c1, f1, l1, c2, f2;
        for (int k = 0; k < int'(n) - 1; k++) press(keys[31-4*k -: 4]);
        chk({name, "_cnt"}, 32'(digit_count), 32'(exp_cnt));
        press(keys[31-4*(int'(n)-1) -: 4]);
        c0 = pin_check; f0 = pin_fail;
        @(posedge clk); #1;
        c1 = pin_check; f1 = pin_fail; l1 = locked;
        @(posedge clk); #1;
        c2 = pin_check; f2 = pin_fail;
        chk({name, "_check"}, 32'(c1), 32'(exp_c));
        chk({name, "_fail"}, 32'(f1), 32'(exp_f));
        chk({name, "_locked"}, 32'(l1), 32'(exp_l));
        chk({name, "_onecycle"}, 32'({c0, f0, c2, f2}), 32'd0);
        if (!exp_l) chk({name, "_cnt_clr"}, 32'(digit_count), 32'd0);
        $display("attempt %s keys=%h n=%0d check=%0d fail=%0d locked=%0d", name, keys, n, c1, f1, l1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lk;
        int pulses;
        int i;
        logic [3:0] script [5];
        logic seen_fail;

        tbl[0]  = '{1'b0, 16'h0000, 4'd5, 32'h1234B000, 3'd4, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 4'd5, 32'h1235B000, 3'd4, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 4'd6, 32'h12345B00, 3'd4, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 4'd5, 32'h1234B000, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 4'd3, 32'h12B00000, 3'd2, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 16'h0000, 4'd8, 32'h12A1234B, 3'd4, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 4'd1, 32'hB0000000, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 4'd6, 32'h12C34B00, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 16'h9081, 4'd5, 32'h9081B000, 3'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 4'd5, 32'h1234B000, 3'd4, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 16'h12A4, 4'd5, 32'h9081B000, 3'd4, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pin_check", 32'(pin_check), 32'd0);
        chk("rst_pin_fail", 32'(pin_fail), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_digit_count", 32'(digit_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++) begin
            if (tbl[v].do_set) load_pin(tbl[v].set_val);
            attempt($sformatf("v%0d", v), tbl[v].nkeys, tbl[v].keys, tbl[v].exp_cnt,
                    tbl[v].exp_check, tbl[v].exp_fail, 1'b0);
        end

        // Lockout: PIN is now 9081, fail counter 0.
        attempt("lk1", 4'd5, 32'h0000B000, 3'd4, 1'b0, 1'b1, 1'b0);
        attempt("lk2", 4'd5, 32'h0000B000, 3'd4, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) press(4'd0);
        press(4'hB);
        @(posedge clk); #1;
        chk("lk3_fail", 32'(pin_fail), 32'd1);
        chk("lk3_locked_rise", 32'(locked), 32'd1);
        script[0] = 4'd9; script[1] = 4'd0; script[2] = 4'd8; script[3] = 4'd1; script[4] = 4'hB;
        lk = 0; pulses = 0; i = 0;
        while (locked && i < 60) begin
            lk++;
            key_valid = (i < 5);
            key_code  = (i < 5) ? script[i] : 4'd0;
            pin_set   = (i == 6);
            pin_new   = 16'h5678;
            @(posedge clk); #1;
            key_valid = 1'b0;
            pin_set   = 1'b0;
            pulses += int'(pin_check) + int'(pin_fail);
            i++;
        end
        chk("lock_len", 32'(lk), 32'd21);
        chk("lock_no_pulse", 32'(pulses), 32'd0);
        $display("lockout locked_cycles=%0d pulses=%0d", lk, pulses);
        attempt("post_lock", 4'd5, 32'h9081B000, 3'd4, 1'b1, 1'b0, 1'b0);
        attempt("post_lock_f", 4'd5, 32'h0000B000, 3'd4, 1'b0, 1'b1, 1'b0);
        attempt("post_lock_ok", 4'd5, 32'h9081B000, 3'd4, 1'b1, 1'b0, 1'b0);

        // pin_set together with a key: key wins, stored PIN unchanged.
        pin_set = 1'b1; pin_new = 16'h5555;
        press(4'd1);
        pin_set = 1'b0;
        chk("set_key_cnt", 32'(digit_count), 32'd1);
        press(4'hA);
        $display("set_with_key digit_count_after_clear=%0d", digit_count);
        attempt("set_key_pin", 4'd5, 32'h9081B000, 3'd4, 1'b1, 1'b0, 1'b0);

        // Inter-key timeout.
        press(4'd1);
        seen_fail = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen_fail |= pin_fail;
        end
`ifdef PIN_TIMEOUT_EN
        chk("timeout_cnt", 32'(digit_count), 32'd0);
`else
        chk("timeout_cnt", 32'(digit_count), 32'd1);
        press(4'hA);
`endif
        chk("timeout_no_fail", 32'(seen_fail), 32'd0);
        $display("timeout digit_count=%0d fail_seen=%0d", digit_count, seen_fail);

        // Reset restores the default PIN.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        attempt("rst_pin", 4'd5, 32'h1234B000, 3'd4, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
